// File: rtl/instruction_fetch_ctrl_pkg.sv
// Shared constants for the instruction fetch controller: default widths,
// reset vector and the 2-bit FSM state encodings.
package instruction_fetch_ctrl_pkg;

    localparam int PC_SIZE_DEF          = 16;
    localparam int INSTRUCTION_SIZE_DEF = 16;

    // Legacy-compatible state encodings (2-bit).
    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    // Depth of the prefetch queue; count needs two bits to reach 2.
    localparam logic [1:0] QUEUE_DEPTH = 2'd2;

endpackage

// File: rtl/instruction_fetch_ctrl_fetch_queue.sv
// Two-entry prefetch FIFO. Slot 0 is always the head, so the head outputs
// are plain registers and keep their last value when the queue drains.
// Flush beats push and pop; a push into a full queue only lands when a pop
// frees a slot in the same cycle.
module instruction_fetch_ctrl_fetch_queue
    import instruction_fetch_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] slot0_r;
    logic [W-1:0] slot1_r;
    logic [1:0]   count_r;
    logic         pop_ok_s;
    logic         push_ok_s;

    // Qualify requests against the current occupancy.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (count_r != 2'd0) begin
            pop_ok_s = pop;
        end else begin
            pop_ok_s = 1'b0;
        end
        if ((count_r != QUEUE_DEPTH) || pop_ok_s) begin
            push_ok_s = push;
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Storage and occupancy update; flush only clears the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_r <= {W{1'b0}};
            slot1_r <= {W{1'b0}};
            count_r <= 2'd0;
        end else if (flush) begin
            count_r <= 2'd0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        slot0_r <= din;
                    end else begin
                        slot1_r <= din;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    if (count_r == QUEUE_DEPTH) begin
                        slot0_r <= slot1_r;
                    end
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == QUEUE_DEPTH) begin
                        slot0_r <= slot1_r;
                        slot1_r <= din;
                    end else begin
                        slot0_r <= din;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign head  = slot0_r;
    assign count = count_r;

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, captures combinational
// ROM data into a 2-entry prefetch queue and hands {instruction, pc} to
// decode over valid/ready. Redirects flush the queue; halt stops pushes
// while queued entries drain.
module instruction_fetch_ctrl
    import instruction_fetch_ctrl_pkg::*;
#(
    parameter int                 PC_SIZE          = PC_SIZE_DEF,
    parameter int                 INSTRUCTION_SIZE = INSTRUCTION_SIZE_DEF,
    parameter logic [PC_SIZE-1:0] RESET_VECTOR     = {PC_SIZE{1'b0}}
) (
    input  logic                        CLK,
    input  logic                        RESET_N,
    output logic [PC_SIZE-1:0]          FETCH_PC,
    input  logic [INSTRUCTION_SIZE-1:0] IMEM_INSTR,
    output logic                        INSTR_VALID,
    output logic [INSTRUCTION_SIZE-1:0] INSTR,
    output logic [PC_SIZE-1:0]          INSTR_PC,
    input  logic                        INSTR_READY,
    input  logic                        REDIRECT_VALID,
    input  logic [PC_SIZE-1:0]          REDIRECT_PC,
    input  logic                        HALT_REQ,
    output logic                        HALTED,
    output logic                        ALIGN_ERR
);

    localparam int QW = INSTRUCTION_SIZE + PC_SIZE;

    logic [1:0]         state_r;
    logic [1:0]         state_next_s;
    logic [PC_SIZE-1:0] fetch_pc_r;
    logic               align_err_r;
    logic [1:0]         count_s;
    logic [QW-1:0]      head_s;
    logic               pop_s;
    logic               push_s;
    logic               redirect_s;

    // Handshake, redirect qualification and push decision.
    always_comb begin
        pop_s      = INSTR_VALID & INSTR_READY;
        redirect_s = 1'b0;
        push_s     = 1'b0;
        if (state_r != S_BOOT) begin
            redirect_s = REDIRECT_VALID;
        end else begin
            redirect_s = 1'b0;
        end
        if ((state_r == S_FETCH) && !HALT_REQ && !REDIRECT_VALID &&
            ((count_s != QUEUE_DEPTH) || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Next-state logic: BOOT lasts one cycle, HALT_REQ level selects HALT.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_BOOT:  state_next_s = HALT_REQ ? S_HALT : S_FETCH;
            S_FETCH: state_next_s = HALT_REQ ? S_HALT : S_FETCH;
            S_HALT:  state_next_s = HALT_REQ ? S_HALT : S_FETCH;
            default: state_next_s = S_BOOT;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= S_BOOT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Fetch PC: redirect target (forced even) wins over sequential advance.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fetch_pc_r <= RESET_VECTOR;
        end else if (redirect_s) begin
            fetch_pc_r <= {REDIRECT_PC[PC_SIZE-1:1], 1'b0};
        end else if (push_s) begin
            fetch_pc_r <= fetch_pc_r + PC_SIZE'(2);
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    // Sticky misaligned-redirect flag, cleared only by reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            align_err_r <= 1'b0;
        end else if (redirect_s && REDIRECT_PC[0]) begin
            align_err_r <= 1'b1;
        end else begin
            align_err_r <= align_err_r;
        end
    end

    instruction_fetch_ctrl_fetch_queue #(
        .W (QW)
    ) u_queue (
        .clk   (CLK),
        .rst_n (RESET_N),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect_s),
        .din   ({IMEM_INSTR, fetch_pc_r}),
        .head  (head_s),
        .count (count_s)
    );

    assign FETCH_PC    = fetch_pc_r;
    assign INSTR_VALID = (count_s != 2'd0);
    assign INSTR       = head_s[QW-1:PC_SIZE];
    assign INSTR_PC    = head_s[PC_SIZE-1:0];
    assign HALTED      = (state_r == S_HALT) && (count_s == 2'd0);
    assign ALIGN_ERR   = align_err_r;

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Directed bench for instruction_fetch_ctrl. The ROM returns PC ^ 16'h5A00,
// so every expected instruction below is hand-derived from its address.
module tb_instruction_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [15:0] FETCH_PC;
    logic [15:0] IMEM_INSTR;
    logic        INSTR_VALID;
    logic [15:0] INSTR;
    logic [15:0] INSTR_PC;
    logic        INSTR_READY;
    logic        REDIRECT_VALID;
    logic [15:0] REDIRECT_PC;
    logic        HALT_REQ;
    logic        HALTED;
    logic        ALIGN_ERR;

    int vectors    = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    assign IMEM_INSTR = FETCH_PC ^ 16'h5A00;

    instruction_fetch_ctrl dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .FETCH_PC       (FETCH_PC),
        .IMEM_INSTR     (IMEM_INSTR),
        .INSTR_VALID    (INSTR_VALID),
        .INSTR          (INSTR),
        .INSTR_PC       (INSTR_PC),
        .INSTR_READY    (INSTR_READY),
        .REDIRECT_VALID (REDIRECT_VALID),
        .REDIRECT_PC    (REDIRECT_PC),
        .HALT_REQ       (HALT_REQ),
        .HALTED         (HALTED),
        .ALIGN_ERR      (ALIGN_ERR)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [15:0] pc);
        chk({tag, "_valid"}, 32'(INSTR_VALID), 32'd1);
        chk({tag, "_pc"}, 32'(INSTR_PC), 32'(pc));
        chk({tag, "_instr"}, 32'(INSTR), 32'(pc ^ 16'h5A00));
    endtask

    initial begin
        RESET_N        = 1'b0;
        INSTR_READY    = 1'b1;
        REDIRECT_VALID = 1'b0;
        REDIRECT_PC    = 16'h0000;
        HALT_REQ       = 1'b0;
        #12;
        // Reset values
        chk("rst_fetch_pc", 32'(FETCH_PC), 32'h0000);
        chk("rst_valid", 32'(INSTR_VALID), 32'd0);
        chk("rst_instr", 32'(INSTR), 32'h0000);
        chk("rst_instr_pc", 32'(INSTR_PC), 32'h0000);
        chk("rst_halted", 32'(HALTED), 32'd0);
        chk("rst_align", 32'(ALIGN_ERR), 32'd0);
        tick();
        RESET_N = 1'b1;

        // Test 1: boot cycle then one instruction per cycle
        tick();
        chk("t1_boot_valid", 32'(INSTR_VALID), 32'd0);
        tick();
        chk_head("t1_a", 16'h0000);
        chk("t1_a_fpc", 32'(FETCH_PC), 32'h0002);
        tick();
        chk_head("t1_b", 16'h0002);
        tick();
        chk_head("t1_c", 16'h0004);
        tick();
        chk_head("t1_d", 16'h0006);
        chk("t1_d_fpc", 32'(FETCH_PC), 32'h0008);

        // Async reset mid-stream
        #2;
        RESET_N = 1'b0;
        #1;
        chk("arst_valid", 32'(INSTR_VALID), 32'd0);
        chk("arst_fpc", 32'(FETCH_PC), 32'h0000);
        INSTR_READY = 1'b0;
        tick();
        RESET_N = 1'b1;

        // Test 2: back-pressure saturates the queue at 2
        tick();
        tick();
        tick();
        repeat (5) tick();
        chk_head("t2_hold", 16'h0000);
        chk("t2_hold_fpc", 32'(FETCH_PC), 32'h0004);
        INSTR_READY = 1'b1;
        tick();
        chk_head("t2_b", 16'h0002);
        tick();
        chk_head("t2_c", 16'h0004);
        tick();
        chk_head("t2_d", 16'h0006);
        chk("t2_d_fpc", 32'(FETCH_PC), 32'h000A);

        // Test 3: redirect while full and popping
        REDIRECT_VALID = 1'b1;
        REDIRECT_PC    = 16'h0010;
        tick();
        REDIRECT_VALID = 1'b0;
        chk("t3_flush_valid", 32'(INSTR_VALID), 32'd0);
        chk("t3_fpc", 32'(FETCH_PC), 32'h0010);
        tick();
        chk_head("t3_tgt", 16'h0010);
        tick();
        chk_head("t3_next", 16'h0012);

        // Test 4: misaligned redirect sets sticky ALIGN_ERR
        REDIRECT_VALID = 1'b1;
        REDIRECT_PC    = 16'h0013;
        tick();
        chk("t4_fpc", 32'(FETCH_PC), 32'h0012);
        chk("t4_align", 32'(ALIGN_ERR), 32'd1);
        chk("t4_valid", 32'(INSTR_VALID), 32'd0);
        REDIRECT_PC = 16'h0020;
        tick();
        REDIRECT_VALID = 1'b0;
        chk("t4_fpc2", 32'(FETCH_PC), 32'h0020);
        chk("t4_align_sticky", 32'(ALIGN_ERR), 32'd1);
        tick();
        chk_head("t4_tgt", 16'h0020);

        // Test 5: halt with two queued entries, drain, resume
        INSTR_READY = 1'b0;
        tick();
        chk("t5_full_fpc", 32'(FETCH_PC), 32'h0024);
        HALT_REQ    = 1'b1;
        INSTR_READY = 1'b1;
        tick();
        chk_head("t5_pop1", 16'h0022);
        chk("t5_halted0", 32'(HALTED), 32'd0);
        tick();
        chk("t5_empty", 32'(INSTR_VALID), 32'd0);
        chk("t5_halted1", 32'(HALTED), 32'd1);
        tick();
        tick();
        chk("t5_fpc_frozen", 32'(FETCH_PC), 32'h0024);
        chk("t5_halted2", 32'(HALTED), 32'd1);
        HALT_REQ = 1'b0;
        tick();
        chk("t5_unhalt", 32'(HALTED), 32'd0);
        chk("t5_unhalt_valid", 32'(INSTR_VALID), 32'd0);
        tick();
        chk_head("t5_resume", 16'h0024);

        // Test 6: PC wraps from FFFE to 0000
        REDIRECT_VALID = 1'b1;
        REDIRECT_PC    = 16'hFFFC;
        tick();
        REDIRECT_VALID = 1'b0;
        chk("t6_fpc", 32'(FETCH_PC), 32'hFFFC);
        tick();
        tick();
        chk_head("t6_top", 16'hFFFE);
        chk("t6_wrap_fpc", 32'(FETCH_PC), 32'h0000);
        tick();
        chk_head("t6_zero", 16'h0000);
        chk("t6_after_fpc", 32'(FETCH_PC), 32'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
